i2s_sample_scheduler: RTL

I2S_SAMPLE_SCHEDULER -- requirements
Module: i2s_sample_scheduler

---
 rtl/i2s_sample_scheduler_if.sv | 26 ++
 rtl/i2s_sample_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/i2s_sample_scheduler_if.sv
// Purpose : source-side sample bus for i2s_sample_scheduler (left = A, right = B).
// Latency : n/a (signal bundle only).
// Backpressure: a sample transfers on a CLK edge where VALID and READY are both high.
//
// Ports:
//   A_DATA/A_VALID/A_READY  left (or mono) source sample, 16-bit two's complement
//   B_DATA/B_VALID/B_READY  right source sample
//   master = sample producer, slave = scheduler
interface i2s_sample_scheduler_if;
  logic [15:0] A_DATA;
  logic        A_VALID;
  logic        A_READY;
  logic [15:0] B_DATA;
  logic        B_VALID;
  logic        B_READY;

  modport master (
    output A_DATA, A_VALID, B_DATA, B_VALID,
    input  A_READY, B_READY
  );

  modport slave (
    input  A_DATA, A_VALID, B_DATA, B_VALID,
    output A_READY, B_READY
  );
endinterface

// File: rtl/i2s_sample_scheduler.sv
// Purpose : buffers left/right samples and hands one to the I2S master per LCK slot.
// Latency : SMP is registered on the CLK edge that sees the LCK transition (1 CLK after it).
// Backpressure: per-channel READY drops while that FIFO is full or RST is high.
//
// Ports:
//   CLK, RST      system clock, synchronous active-high reset
//   LCK           I2S word clock (0 = left slot, 1 = right slot), synchronous to CLK
//   MONO          1 = left source feeds both slots (sampled only on rising LCK)
//   CLR           clears the sticky UNDERRUN flags
//   src           A/B sample push bus (slave side)
//   SMP           sample presented to the I2S master
//   UNDERRUN      sticky flags: bit0 = A empty at its slot, bit1 = B empty at its slot
module i2s_sample_scheduler #(
  parameter int DEPTH            = 4,   // entries per channel FIFO, power of 2, >= 2
  parameter int MUTE_ON_UNDERRUN = 1    // 1 = send zero on underrun, 0 = repeat last sample
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        LCK,
  input  logic                        MONO,
  input  logic                        CLR,
  i2s_sample_scheduler_if.slave       src,
  output logic [15:0]                 SMP,
  output logic [1:0]                  UNDERRUN
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int unsigned ONE      = 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  // slot edge detection
  logic lck_d;
  logic lck_edge;
  logic lck_fall;
  logic lck_rise;

  // per-channel FIFO state
  logic [15:0]   mem_a [DEPTH];
  logic [15:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_a, rd_a, wr_b, rd_b;
  logic [AW:0]   cnt_a, cnt_b;
  logic          full_a, full_b, empty_a, empty_b;
  logic          push_a, push_b, pop_a, pop_b;
  logic [15:0]   head_a, head_b;

  // slot scheduling
  logic [15:0]   last_a, last_b;
  logic [15:0]   smp_nxt;
  logic          under_a, under_b;

  assign lck_edge = (LCK != lck_d);
  assign lck_fall = lck_edge & ~LCK;
  assign lck_rise = lck_edge &  LCK;

  assign empty_a = (cnt_a == '0);
  assign empty_b = (cnt_b == '0);
  assign full_a  = (cnt_a == FULL_CNT);
  assign full_b  = (cnt_b == FULL_CNT);

  // READY comes from registered occupancy only, so a pop does not reopen a
  // full FIFO until the following cycle.
  assign src.A_READY = ~full_a & ~RST;
  assign src.B_READY = ~full_b & ~RST;

  assign push_a = src.A_VALID & src.A_READY;
  assign push_b = src.B_VALID & src.B_READY;

  assign head_a = mem_a[rd_a];
  assign head_b = mem_b[rd_b];

  // Slot decision. Emptiness is the registered count, so a push landing in the
  // same cycle as its slot is not visible to that slot (no bypass path).
  always_comb begin
    pop_a   = 1'b0;
    pop_b   = 1'b0;
    under_a = 1'b0;
    under_b = 1'b0;
    smp_nxt = SMP;
    if (lck_fall) begin
      if (!empty_a) begin
        pop_a   = 1'b1;
        smp_nxt = head_a;
      end else begin
        under_a = 1'b1;
        smp_nxt = (MUTE_ON_UNDERRUN != 0) ? 16'h0000 : last_a;
      end
    end else if (lck_rise) begin
      if (MONO) begin
        // mono repeats the left sample; B is left untouched
        smp_nxt = last_a;
      end else if (!empty_b) begin
        pop_b   = 1'b1;
        smp_nxt = head_b;
      end else begin
        under_b = 1'b1;
        smp_nxt = (MUTE_ON_UNDERRUN != 0) ? 16'h0000 : last_b;
      end
    end
  end

  // sample storage carries no reset; validity is tracked by the counters
  always_ff @(posedge CLK) begin
    if (push_a) mem_a[wr_a] <= src.A_DATA;
    if (push_b) mem_b[wr_b] <= src.B_DATA;
  end

  always_ff @(posedge CLK) begin
    // tracks LCK through reset so release never looks like a slot edge
    lck_d <= LCK;
    if (RST) begin
      wr_a     <= '0;
      rd_a     <= '0;
      cnt_a    <= '0;
      wr_b     <= '0;
      rd_b     <= '0;
      cnt_b    <= '0;
      last_a   <= '0;
      last_b   <= '0;
      SMP      <= '0;
      UNDERRUN <= '0;
    end else begin
      if (push_a) wr_a <= wr_a + ONE[AW-1:0];
      if (push_b) wr_b <= wr_b + ONE[AW-1:0];
      if (pop_a) begin
        rd_a   <= rd_a + ONE[AW-1:0];
        last_a <= head_a;
      end
      if (pop_b) begin
        rd_b   <= rd_b + ONE[AW-1:0];
        last_b <= head_b;
      end
      if (push_a && !pop_a)      cnt_a <= cnt_a + ONE[AW:0];
      else if (!push_a && pop_a) cnt_a <= cnt_a - ONE[AW:0];
      if (push_b && !pop_b)      cnt_b <= cnt_b + ONE[AW:0];
      else if (!push_b && pop_b) cnt_b <= cnt_b - ONE[AW:0];
      SMP <= smp_nxt;
      // a fresh underrun beats a coincident clear
      UNDERRUN <= (CLR ? 2'b00 : UNDERRUN) | {under_b, under_a};
    end
  end

endmodule
